// File: rtl/uart_rx_core.sv
// UART 8N1 receiver: 2-flop synchronizer, mid-bit sampling FSM and a one-entry
// valid/ready output slot with framing-error and overrun pulses.
module uart_rx_core #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int BIT_RATE  = 9600,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  output logic                 busy_o
);

  localparam int CLKS_PER_BIT = CLK_HZ / BIT_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W        = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  state_t               state;
  logic                 meta_reg;
  logic                 rx_s;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     idx;
  logic [DATA_BITS-1:0] shift_reg;

  // Idle-high line, so the synchronizer resets to 1 to avoid a false start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_reg <= 1'b1;
      rx_s     <= 1'b1;
    end else begin
      meta_reg <= rx_i;
      rx_s     <= meta_reg;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      shift_reg   <= '0;
      data_o      <= '0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;

      // A consume frees the slot; a delivery later in this block overrides it.
      if (valid_o && ready_i)
        valid_o <= 1'b0;

      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_s) begin
            state  <= START;
            busy_o <= 1'b1;
          end
        end

        START: begin
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            if (!rx_s) begin
              state <= DATA;
              idx   <= '0;
            end else begin
              state  <= IDLE;
              busy_o <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DATA: begin
          if (cnt == CNT_FULL) begin
            cnt       <= '0;
            shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
            if (idx == IDX_LAST) begin
              state <= STOP;
              idx   <= '0;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        STOP: begin
          if (cnt == CNT_FULL) begin
            cnt <= '0;
            if (rx_s) begin
              state  <= IDLE;
              busy_o <= 1'b0;
              if (!valid_o || ready_i) begin
                data_o  <= shift_reg;
                valid_o <= 1'b1;
              end else begin
                overrun_o <= 1'b1;
              end
            end else begin
              frame_err_o <= 1'b1;
              state       <= WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        WAIT_HIGH: begin
          cnt <= '0;
          if (rx_s) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
        end

        default: begin
          state  <= IDLE;
          cnt    <= '0;
          idx    <= '0;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: frames are built from bytes by plain
// arithmetic, and received bytes/pulses are compared against expected outcomes.
module tb_uart_rx_core;

  localparam int CLK_HZ   = 1_000_000;
  localparam int BIT_RATE = 100_000;
  localparam int CPB      = CLK_HZ / BIT_RATE;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_i = 1'b1;
  logic       ready_i = 1'b0;
  logic [7:0] data_o;
  logic       valid_o, frame_err_o, overrun_o, busy_o;

  int n_cmp = 0;
  int n_bad = 0;

  int   cyc = 0;
  int   start_cyc = 0;
  int   last_rise = -1;
  int   rise_cnt = 0;
  int   fe_cnt = 0;
  int   ov_cnt = 0;
  logic valid_prev = 1'b0;
  logic [7:0] got_q[$];

  uart_rx_core #(.CLK_HZ(CLK_HZ), .BIT_RATE(BIT_RATE), .DATA_BITS(8)) dut (
    .clk(clk), .reset(reset), .rx_i(rx_i), .data_o(data_o), .valid_o(valid_o),
    .ready_i(ready_i), .frame_err_o(frame_err_o), .overrun_o(overrun_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (reset) begin
      valid_prev = 1'b0;
    end else begin
      if (valid_o && ready_i) got_q.push_back(data_o);
      if (frame_err_o) fe_cnt++;
      if (overrun_o) ov_cnt++;
      if (valid_o && !valid_prev) begin
        rise_cnt++;
        last_rise = cyc;
      end
      valid_prev = valid_o;
    end
  end

  // Start bit, DATA bits LSB first, then the given stop level; CPB clocks each.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    @(posedge clk);
    #1 rx_i = 1'b0;
    start_cyc = cyc;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 rx_i = ((b >> i) & 8'd1) != 0;
      repeat (CPB) @(posedge clk);
    end
    #1 rx_i = stop;
    repeat (CPB) @(posedge clk);
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (data_o !== 8'h00) begin n_bad++; $display("FAIL reset_data got=%h exp=00", data_o); end
    n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
    n_cmp++; if (frame_err_o !== 1'b0) begin n_bad++; $display("FAIL reset_fe got=%b exp=0", frame_err_o); end
    n_cmp++; if (overrun_o !== 1'b0) begin n_bad++; $display("FAIL reset_ov got=%b exp=0", overrun_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    reset = 1'b0;
    repeat (3) @(posedge clk);
    $display("reset: outputs checked");
  endtask

  task automatic test_single;
    int fe0, ov0, r0, lat;
    fe0 = fe_cnt; ov0 = ov_cnt; r0 = rise_cnt;
    got_q.delete();
    ready_i = 1'b1;
    send_frame(8'hA5, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    lat = last_rise - start_cyc;
    n_cmp++; if (got_q.size() != 1) begin n_bad++; $display("FAIL single_count got=%0d exp=1", got_q.size()); end
    else begin
      n_cmp++; if (got_q[0] !== 8'hA5) begin n_bad++; $display("FAIL single_data got=%h exp=a5", got_q[0]); end
    end
    n_cmp++; if (rise_cnt - r0 != 1) begin n_bad++; $display("FAIL single_rises got=%0d exp=1", rise_cnt - r0); end
    n_cmp++; if (fe_cnt != fe0 || ov_cnt != ov0) begin n_bad++; $display("FAIL single_flags fe=%0d ov=%0d exp=0/0", fe_cnt - fe0, ov_cnt - ov0); end
    n_cmp++; if (lat < 97 || lat > 99) begin n_bad++; $display("FAIL single_latency got=%0d exp=97..99", lat); end
    $display("single: byte a5 latency=%0d", lat);
  endtask

  task automatic test_random;
    logic [7:0] exp_q[$];
    logic [7:0] b;
    got_q.delete();
    ready_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      b = 8'($urandom_range(0, 255));
      exp_q.push_back(b);
      send_frame(b, 1'b1);
      repeat ($urandom_range(0, 4)) @(posedge clk);
    end
    repeat (20) @(posedge clk);
    #1;
    n_cmp++; if (got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL random_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    else begin
      for (int k = 0; k < exp_q.size(); k++) begin
        n_cmp++;
        if (got_q[k] !== exp_q[k]) begin n_bad++; $display("FAIL random_byte%0d got=%h exp=%h", k, got_q[k], exp_q[k]); end
        else $display("random: byte %0d = %h", k, got_q[k]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int ov0;
    ov0 = ov_cnt;
    got_q.delete();
    ready_i = 1'b0;
    send_frame(8'h01, 1'b1);
    send_frame(8'h02, 1'b1);
    #1;
    n_cmp++; if (valid_o !== 1'b1) begin n_bad++; $display("FAIL bp_valid_held got=%b exp=1", valid_o); end
    n_cmp++; if (data_o !== 8'h01) begin n_bad++; $display("FAIL bp_data_held got=%h exp=01", data_o); end
    n_cmp++; if (ov_cnt - ov0 != 1) begin n_bad++; $display("FAIL bp_overrun got=%0d exp=1", ov_cnt - ov0); end
    @(posedge clk);
    #1 ready_i = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL bp_valid_fall got=%b exp=0", valid_o); end
    repeat (20) @(posedge clk);
    #1;
    n_cmp++; if (got_q.size() != 1) begin n_bad++; $display("FAIL bp_count got=%0d exp=1", got_q.size()); end
    else begin
      n_cmp++; if (got_q[0] !== 8'h01) begin n_bad++; $display("FAIL bp_byte got=%h exp=01", got_q[0]); end
    end
    $display("back_to_back: overruns=%0d", ov_cnt - ov0);
  endtask

  task automatic test_frame_err;
    int fe0, r0;
    fe0 = fe_cnt; r0 = rise_cnt;
    ready_i = 1'b1;
    send_frame(8'h3C, 1'b0);
    repeat (29) @(posedge clk);
    #1;
    n_cmp++; if (busy_o !== 1'b1) begin n_bad++; $display("FAIL fe_busy_low got=%b exp=1", busy_o); end
    rx_i = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL fe_busy_idle got=%b exp=0", busy_o); end
    n_cmp++; if (fe_cnt - fe0 != 1) begin n_bad++; $display("FAIL fe_pulses got=%0d exp=1", fe_cnt - fe0); end
    n_cmp++; if (rise_cnt != r0) begin n_bad++; $display("FAIL fe_no_valid got=%0d exp=0", rise_cnt - r0); end
    got_q.delete();
    send_frame(8'h55, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    n_cmp++; if (got_q.size() != 1 || got_q[0] !== 8'h55) begin n_bad++; $display("FAIL fe_recover count=%0d exp=1 byte=55", got_q.size()); end
    $display("frame_err: pulses=%0d", fe_cnt - fe0);
  endtask

  task automatic test_glitch;
    int r0;
    r0 = rise_cnt;
    @(posedge clk);
    #1 rx_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rx_i = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++; if (busy_o !== 1'b1) begin n_bad++; $display("FAIL glitch_seen got=%b exp=1", busy_o); end
    repeat (6) @(posedge clk);
    #1;
    n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL glitch_idle got=%b exp=0", busy_o); end
    n_cmp++; if (rise_cnt != r0) begin n_bad++; $display("FAIL glitch_no_valid got=%0d exp=0", rise_cnt - r0); end
    $display("glitch: busy=%b", busy_o);
  endtask

  task automatic test_consume_deliver;
    int ov0;
    got_q.delete();
    ready_i = 1'b0;
    send_frame(8'h11, 1'b1);
    ov0 = ov_cnt;
    fork
      send_frame(8'h22, 1'b1);
      begin
        @(posedge clk);
        repeat (97) @(posedge clk);
        #1 ready_i = 1'b1;
        @(posedge clk);
        #1 ready_i = 1'b0;
        n_cmp++; if (data_o !== 8'h22) begin n_bad++; $display("FAIL cd_data got=%h exp=22", data_o); end
        n_cmp++; if (valid_o !== 1'b1) begin n_bad++; $display("FAIL cd_valid got=%b exp=1", valid_o); end
      end
    join
    #1;
    n_cmp++; if (ov_cnt != ov0) begin n_bad++; $display("FAIL cd_overrun got=%0d exp=0", ov_cnt - ov0); end
    ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (got_q.size() != 2 || got_q[0] !== 8'h11 || got_q[1] !== 8'h22) begin
      n_bad++; $display("FAIL cd_stream count=%0d exp=2 (11,22)", got_q.size());
    end
    $display("consume_deliver: transfers=%0d", got_q.size());
  endtask

  task automatic test_reset_mid;
    ready_i = 1'b1;
    fork
      send_frame(8'hFF, 1'b1);
      begin
        @(posedge clk);
        repeat (55) @(posedge clk);
        #1;
        n_cmp++; if (busy_o !== 1'b1) begin n_bad++; $display("FAIL rm_busy_before got=%b exp=1", busy_o); end
        #1 reset = 1'b1;
        #1;
        n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL rm_busy got=%b exp=0", busy_o); end
        n_cmp++; if (data_o !== 8'h00) begin n_bad++; $display("FAIL rm_data got=%h exp=00", data_o); end
        n_cmp++; if (valid_o !== 1'b0 || frame_err_o !== 1'b0 || overrun_o !== 1'b0) begin
          n_bad++; $display("FAIL rm_flags got=%b%b%b exp=000", valid_o, frame_err_o, overrun_o);
        end
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
      end
    join
    got_q.delete();
    send_frame(8'h80, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    n_cmp++; if (got_q.size() != 1 || got_q[0] !== 8'h80) begin n_bad++; $display("FAIL rm_recover count=%0d exp=1 byte=80", got_q.size()); end
    $display("reset_mid: recovered frames=%0d", got_q.size());
  endtask

  initial begin
    test_reset();
    test_single();
    test_random();
    test_back_to_back();
    test_frame_err();
    test_glitch();
    test_consume_deliver();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
- UART receiver: the receive end of the serial link whose transmit side is uart_tx.
- Samples asynchronous rx_i, recovers 8N1 frames (LSB first) at a fixed bit rate, and presents each byte on a one-entry valid/ready output.
- Flags framing errors and overruns.
- Sits between the board RX pin and the consumer logic in uart_allocation.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency in Hz.
- BIT_RATE, 9600, serial bit rate in bit/s.
- DATA_BITS, 8, data bits per frame (legal range 5..8).
- Derived, not overridable: CLKS_PER_BIT = CLK_HZ / BIT_RATE (integer divide); HALF_BIT = CLKS_PER_BIT / 2; counter width = $clog2(CLKS_PER_BIT).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- rx_i  input  1  serial line, idle high, asynchronous to clk.
- data_o  output  DATA_BITS  received byte, stable while valid_o=1.
- valid_o  output  1  data_o holds an unconsumed byte.
- ready_i  input  1  consumer accepts; transfer occurs when valid_o & ready_i.
- frame_err_o  output  1  one-cycle pulse: stop bit sampled low.
- overrun_o  output  1  one-cycle pulse: completed byte dropped because the slot was full.
- busy_o  output  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, active-high) clears every register:
  - data_o=0, valid_o=0, frame_err_o=0, overrun_o=0, busy_o=0.
  - Both synchronizer flops = 1.
  - State = IDLE; bit counter and bit index = 0.
- Reset asserted mid-frame aborts the frame immediately. The partial byte is lost and no flag pulses.
- rx_i passes through a 2-flop synchronizer, giving rx_s. All FSM decisions use rx_s, so detection latency is 2 cycles.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: when rx_s=0, go to START and clear the counter.
  - START: count to HALF_BIT-1, then sample rx_s.
    - rx_s=0: go to DATA; clear counter and bit index.
    - rx_s=1: glitch; return to IDLE with no flag.
  - DATA: count to CLKS_PER_BIT-1, then sample.
    - Shift the sample in at the MSB (right shift), so the first bit lands at bit 0 after DATA_BITS shifts.
    - Increment the index and clear the counter.
    - After the DATA_BITS-th sample, go to STOP.
  - STOP: count to CLKS_PER_BIT-1, then sample.
    - rx_s=1: deliver the byte; go to IDLE.
    - rx_s=0: frame_err_o=1 for that one cycle (the cycle after the sample); discard the byte; go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s=1, then go to IDLE. This stops a held-low break from re-triggering reception.
- Counter: wraps to 0 on every sample event. It never exceeds CLKS_PER_BIT-1.
- Delivery, evaluated in the cycle of a good stop sample:
  - Slot is free if valid_o=0, or valid_o=1 and ready_i=1 in the same cycle.
  - Free slot: data_o and valid_o=1 are updated at the next edge.
  - Slot not free: overrun_o pulses 1 cycle; data_o keeps the old byte; valid_o stays 1.
- Handshake:
  - valid_o falls at the edge after valid_o & ready_i, unless a delivery occurs on that same edge (then valid_o stays 1 with new data).
  - data_o never changes while valid_o=1 and ready_i=0.
  - ready_i has no effect when valid_o=0.
- Latency: valid_o rises 1 clk after the stop-bit sample. The stop sample falls at mid stop bit, i.e. 2 + HALF_BIT + (DATA_BITS+1)*CLKS_PER_BIT clocks after the line's falling edge, ±1.

Test Plan:
- Bench parameters: CLK_HZ=1_000_000, BIT_RATE=100_000, so CLKS_PER_BIT=10 and HALF_BIT=5.
- Single byte: drive 0xA5 framed 8N1 with ready_i=1 → one valid_o pulse with data_o=0xA5; frame_err_o=0, overrun_o=0; valid_o rises 98±1 clocks after the start edge.
- Back-to-back with backpressure: frames 0x01, 0x02 sent, ready_i=0 until after the second stop → data_o=0x01 held, overrun_o pulses once, then ready_i=1 → valid_o falls, no 0x02 delivered.
- Framing error: 0x3C with the stop bit driven low, then the line held low for 30 clocks → frame_err_o single pulse, valid_o stays 0, busy_o stays 1 until the line returns high; then 0x55 is received correctly.
- Start glitch: rx_i low for 3 clocks then high → no valid_o; FSM returns to IDLE (busy_o=0) within 8 clocks.
- Simultaneous consume and deliver: valid_o=1 holding 0x11, ready_i asserted in the exact cycle 0x22's stop is sampled → data_o=0x22, valid_o stays 1, no overrun_o.
- Reset mid-frame: assert reset at data bit 4 of 0xFF → all outputs 0 immediately; after release, the next frame 0x80 is received correctly.
